arbitro_memoria: RTL and testbench

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria_if.sv | 37 +++
 rtl/arbitro_memoria.sv | 116 +++++++++++
 tb/tb_arbitro_memoria.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Bus bundle between two read requesters, the arbiter and a combinational
// operand memory. The arbiter side uses the slave modport; whoever drives
// the requests and models the memory uses the master modport.
interface arbitro_memoria_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              req0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic              gnt0_o;
    logic              valid0_o;
    logic [DATA_W-1:0] dato0_o;

    logic              req1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic              gnt1_o;
    logic              valid1_o;
    logic [DATA_W-1:0] dato1_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_dato_i;
    logic              busy_o;

    modport slave (
        input  req0_i, addr0_i, req1_i, addr1_i, mem_dato_i,
        output gnt0_o, valid0_o, dato0_o,
        output gnt1_o, valid1_o, dato1_o,
        output mem_addr_o, busy_o
    );

    modport master (
        output req0_i, addr0_i, req1_i, addr1_i, mem_dato_i,
        input  gnt0_o, valid0_o, dato0_o,
        input  gnt1_o, valid1_o, dato1_o,
        input  mem_addr_o, busy_o
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-requester round-robin read arbiter in front of a combinational memory.
// IDLE samples requests and grants one; LEER drives the latched address for a
// single cycle and captures the returned word into the winner's data register.
module arbitro_memoria #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    arbitro_memoria_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LEER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              valid0_q, valid0_d;
    logic              valid1_q, valid1_d;
    logic [DATA_W-1:0] dato0_q, dato0_d;
    logic [DATA_W-1:0] dato1_q, dato1_d;
    logic              pick_w;

    // State and output registers; reset aborts any read in flight and makes
    // requester 0 the winner of the first tie (last_q points at requester 1).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            dato0_q  <= '0;
            dato1_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            win_q    <= win_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            dato0_q  <= dato0_d;
            dato1_q  <= dato1_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, capture memory data when leaving LEER.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        win_d    = win_q;
        last_d   = last_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        dato0_d  = dato0_q;
        dato1_d  = dato1_q;
        pick_w   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    // On a tie the requester not served last wins.
                    if (bus.req0_i && bus.req1_i) begin
                        pick_w = ~last_q;
                    end else begin
                        pick_w = bus.req1_i;
                    end
                    addr_d  = pick_w ? bus.addr1_i : bus.addr0_i;
                    win_d   = pick_w;
                    last_d  = pick_w;
                    gnt0_d  = ~pick_w;
                    gnt1_d  = pick_w;
                    state_d = LEER;
                end
            end
            LEER: begin
                // Requests are not looked at here; a held request is seen
                // again in the following IDLE cycle.
                if (win_q) begin
                    dato1_d  = bus.mem_dato_i;
                    valid1_d = 1'b1;
                end else begin
                    dato0_d  = bus.mem_dato_i;
                    valid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt0_o     = gnt0_q;
    assign bus.gnt1_o     = gnt1_q;
    assign bus.valid0_o   = valid0_q;
    assign bus.valid1_o   = valid1_q;
    assign bus.dato0_o    = dato0_q;
    assign bus.dato1_o    = dato1_q;
    assign bus.mem_addr_o = addr_q;
    assign bus.busy_o     = (state_q == LEER);

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: directed request patterns push the expected
// grant/valid events into a scoreboard queue; a negedge monitor pops one entry
// per observed pulse and compares requester, cycle and data.
module tb_arbitro_memoria;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbitro_memoria_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    arbitro_memoria #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [0:7];
    assign bus.mem_dato_i = mem[bus.mem_addr_o];

    typedef struct {
        bit                kind;   // 0 = grant, 1 = valid
        bit                who;
        int                cyc;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit kind, input bit who, input int c, input logic [DATA_W-1:0] d);
        exp_t e;
        e.kind = kind;
        e.who  = who;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic mon_evt(input bit kind, input bit who, input logic [DATA_W-1:0] d);
        exp_t  e;
        string tag;
        tag = $sformatf("%s%0d", kind ? "valid" : "gnt", who);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, required none", tag, cyc);
        end else begin
            e = sb.pop_front();
            chk({tag, "_kind"}, 64'(kind), 64'(e.kind));
            chk({tag, "_who"}, 64'(who), 64'(e.who));
            chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
            if (kind) chk({tag, "_data"}, 64'(d), 64'(e.data));
        end
    endtask

    // Monitor: exclusivity every cycle, scoreboard pop on every pulse.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_exclusive", 64'(bus.gnt0_o & bus.gnt1_o), 64'd0);
            chk("valid_exclusive", 64'(bus.valid0_o & bus.valid1_o), 64'd0);
            if (bus.gnt0_o)   mon_evt(1'b0, 1'b0, '0);
            if (bus.gnt1_o)   mon_evt(1'b0, 1'b1, '0);
            if (bus.valid0_o) mon_evt(1'b1, 1'b0, bus.dato0_o);
            if (bus.valid1_o) mon_evt(1'b1, 1'b1, bus.dato1_o);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        chk({name, "_pending"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        repeat (2) step();
        chk("rst_gnt", 64'({bus.gnt0_o, bus.gnt1_o}), 64'd0);
        chk("rst_valid", 64'({bus.valid0_o, bus.valid1_o}), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_dato0", 64'(bus.dato0_o), 64'd0);
        chk("rst_dato1", 64'(bus.dato1_o), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        mem[0] = 32'h0000_0002;
        mem[1] = 32'h0000_000A;
        mem[2] = 32'h0000_0022;
        mem[3] = 32'h0000_000F;
        mem[4] = 32'h0000_0044;
        mem[5] = 32'hFFFF_FFFB;
        mem[6] = 32'h0000_0066;
        mem[7] = 32'h0000_0077;
        bus.req0_i  = 1'b0;
        bus.req1_i  = 1'b0;
        bus.addr0_i = '0;
        bus.addr1_i = '0;

        // Single request from requester 0 right after reset.
        do_reset();
        n = cyc;
        bus.req0_i  = 1'b1;
        bus.addr0_i = 3'd1;
        push(1'b0, 1'b0, n + 1, '0);
        push(1'b1, 1'b0, n + 2, 32'h0000_000A);
        step();
        bus.req0_i = 1'b0;
        chk("t1_busy_leer", 64'(bus.busy_o), 64'd1);
        chk("t1_mem_addr_leer", 64'(bus.mem_addr_o), 64'd1);
        step();
        chk("t1_busy_idle", 64'(bus.busy_o), 64'd0);
        chk("t1_dato0", 64'(bus.dato0_o), 64'h0000_000A);
        chk("t1_mem_addr_idle", 64'(bus.mem_addr_o), 64'd1);
        chk("t1_dato1", 64'(bus.dato1_o), 64'd0);
        drain("t1");

        // Both request after reset, each drops its request once granted.
        do_reset();
        n = cyc;
        bus.req0_i  = 1'b1;
        bus.addr0_i = 3'd0;
        bus.req1_i  = 1'b1;
        bus.addr1_i = 3'd5;
        push(1'b0, 1'b0, n + 1, '0);
        push(1'b1, 1'b0, n + 2, 32'h0000_0002);
        push(1'b0, 1'b1, n + 3, '0);
        push(1'b1, 1'b1, n + 4, 32'hFFFF_FFFB);
        step();
        bus.req0_i = 1'b0;
        step();
        chk("t2_dato0", 64'(bus.dato0_o), 64'h0000_0002);
        step();
        bus.req1_i = 1'b0;
        step();
        chk("t2_dato1", 64'(bus.dato1_o), 64'hFFFF_FFFB);
        chk("t2_dato0_hold", 64'(bus.dato0_o), 64'h0000_0002);
        drain("t2");

        // Both held for 8 cycles: alternation, grants 2 cycles apart.
        n = cyc;
        bus.req0_i  = 1'b1;
        bus.addr0_i = 3'd2;
        bus.req1_i  = 1'b1;
        bus.addr1_i = 3'd6;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, k[0], n + 1 + 2 * k, '0);
            push(1'b1, k[0], n + 2 + 2 * k, k[0] ? 32'h0000_0066 : 32'h0000_0022);
        end
        repeat (8) step();
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b0;
        drain("t3");

        // Reset during LEER aborts the read; next tie goes to requester 0.
        n = cyc;
        bus.req1_i  = 1'b1;
        bus.addr1_i = 3'd3;
        push(1'b0, 1'b1, n + 1, '0);
        step();
        bus.req1_i = 1'b0;
        chk("t4_busy_leer", 64'(bus.busy_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t4_busy_abort", 64'(bus.busy_o), 64'd0);
        chk("t4_gnt_abort", 64'({bus.gnt0_o, bus.gnt1_o}), 64'd0);
        chk("t4_dato1_abort", 64'(bus.dato1_o), 64'd0);
        chk("t4_dato0_abort", 64'(bus.dato0_o), 64'd0);
        chk("t4_mem_addr_abort", 64'(bus.mem_addr_o), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("t4_no_valid1", 64'(bus.valid1_o), 64'd0);
        chk("t4_dato1_zero", 64'(bus.dato1_o), 64'd0);
        chk("t4_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        n = cyc;
        bus.req0_i  = 1'b1;
        bus.addr0_i = 3'd4;
        bus.req1_i  = 1'b1;
        bus.addr1_i = 3'd7;
        push(1'b0, 1'b0, n + 1, '0);
        push(1'b1, 1'b0, n + 2, 32'h0000_0044);
        push(1'b0, 1'b1, n + 3, '0);
        push(1'b1, 1'b1, n + 4, 32'h0000_0077);
        step();
        bus.req0_i = 1'b0;
        step();
        step();
        bus.req1_i = 1'b0;
        step();
        drain("t4");

        // Request 0 rising during a requester-1 read waits for the next IDLE.
        n = cyc;
        bus.req1_i  = 1'b1;
        bus.addr1_i = 3'd3;
        push(1'b0, 1'b1, n + 1, '0);
        push(1'b1, 1'b1, n + 2, 32'h0000_000F);
        push(1'b0, 1'b0, n + 3, '0);
        push(1'b1, 1'b0, n + 4, 32'hFFFF_FFFB);
        step();
        bus.req1_i  = 1'b0;
        bus.req0_i  = 1'b1;
        bus.addr0_i = 3'd5;
        step();
        chk("t5_dato1", 64'(bus.dato1_o), 64'h0000_000F);
        chk("t5_dato0_hold_a", 64'(bus.dato0_o), 64'h0000_0044);
        step();
        bus.req0_i = 1'b0;
        chk("t5_dato0_hold_b", 64'(bus.dato0_o), 64'h0000_0044);
        chk("t5_busy", 64'(bus.busy_o), 64'd1);
        chk("t5_mem_addr", 64'(bus.mem_addr_o), 64'd5);
        step();
        chk("t5_dato0_new", 64'(bus.dato0_o), 64'hFFFF_FFFB);
        chk("t5_dato1_hold", 64'(bus.dato1_o), 64'h0000_000F);
        drain("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
